svc_axil_sram_arb: RTL and testbench
====================================

// Module: svc_axil_sram_arb
// PURPOSE
//   Shares one AXI-Lite SRAM target (svc_ice40_axil_sram) between NUM_M AXI-Lite
//   requesters. The single-port SRAM serves one transaction at a time, so this
//   block grants one requester at a time and serialises every transaction.
//   Sits between the CPU, video and DMA masters and the SRAM controller.
// PARAMETERS
//   NUM_M            2   number of requesters (>=2)
//   AXIL_ADDR_WIDTH  16  AXI-Lite address width
//   AXIL_DATA_WIDTH  16  AXI-Lite data width; strobe width SW = DW/8
// PORTS
//   clk                      in   1        clock
//   rst                      in   1        reset, asynchronous, active-high
//   s_axil_awaddr/awvalid    in   N*AW/N   per-requester write address (packed, req i at [i])
//   s_axil_awready           out  N
//   s_axil_wdata/wstrb/wvalid in  N*DW/N*SW/N  per-requester write data
//   s_axil_wready            out  N
//   s_axil_bresp/bvalid      out  N*2/N    write response
//   s_axil_bready            in   N
//   s_axil_araddr/arvalid    in   N*AW/N   read address
//   s_axil_arready           out  N
//   s_axil_rdata/rresp/rvalid out N*DW/N*2/N  read data
//   s_axil_rready            in   N
//   m_axil_*                 -    -        one full AXI-Lite master port to the SRAM, same widths
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - Reset: state=IDLE, grant_valid=0, last_grant=NUM_M-1. All *valid and *ready
//     outputs 0. m_axil_* data/addr/resp outputs 0.
//   - Requests: wr_req[i] = awvalid[i] && wvalid[i]; rd_req[i] = arvalid[i].
//     Requester i requests if either is set. If both are set, the write goes first.
//   - FSM: IDLE -> W_ADDR | R_ADDR -> W_RESP | R_RESP -> IDLE.
//     IDLE: pick a winner among requesters (see CONFIGURATION) and register the
//       grant index and direction. The first forwarded cycle is the next cycle,
//       giving 1 cycle of arbitration latency.
//     W_ADDR: forward the granted aw/w channels to m_axil unchanged.
//       - Latch each of aw and w as it handshakes. The two may complete in
//         different cycles.
//       - Once both have completed, go to W_RESP.
//     R_ADDR: forward ar. On the ar handshake, go to R_RESP.
//     W_RESP/R_RESP: route m bvalid/rvalid and resp/data to the granted requester only.
//       - m bready/rready mirrors the granted requester's ready.
//       - On the b/r handshake, update last_grant to the granted index and go to IDLE.
//   - Non-granted requesters see all ready=0 and all valid=0 at all times.
//     Their requests stay pending; valids are not dropped.
//   - m_axil valids are never asserted in IDLE or in *_RESP.
//   - At most one transaction is outstanding. Read and write are never concurrent.
//   - Valid/ready forwarding is combinational from the registered grant. There is
//     no combinational path from any s_*valid to a grant decision within the same cycle.
//   - Best case per transaction: IDLE(1) + addr (>=1) + resp (>=1).
//   - Reset mid-transaction: everything returns to reset values immediately.
//     In-flight responses are discarded.
// CONFIGURATION
//   SVC_AXIL_SRAM_ARB_RR_EN defined: round-robin.
//     - Search starts at last_grant+1 and wraps at NUM_M-1 -> 0.
//     - The first requester found wins.
//     - A continuously requesting master waits at most NUM_M-1 transactions.
//   Not defined: fixed priority. Lowest index wins. last_grant is kept but unused.
// TESTING
//   1 reset: rst=1 mid W_RESP -> next edge all valids/readys 0, state IDLE;
//     release -> a req0 write completes normally.
//   2 single write/read: req0 writes 0x1234 @0x0040, then reads @0x0040
//     -> bresp=0, rdata=0x1234, rresp=0; req1 valids/readys stay 0 throughout.
//   3 split aw/w: req1 awvalid at t, wvalid at t+3 -> single m write;
//     s_awready[1] and s_wready[1] each pulse once; bvalid[1] only after both.
//   4 contention (RR_EN): req0 and req1 each issue 4 back-to-back writes to
//     0x10+i -> grants alternate 0,1,0,1...; readback of all 8 locations is correct.
//   5 contention (no RR_EN): same stimulus -> all 4 req0 writes complete before req1's first.
//   6 back-pressure: req0 read with rready held 0 for 5 cycles -> rvalid[0] held with
//     stable rdata; req1 arvalid stays pending, granted only after req0's r handshake.

Source files
------------

// File: rtl/svc_axil_sram_arb.sv
// svc_axil_sram_arb: serialises NUM_M AXI-Lite requesters onto one AXI-Lite SRAM target port
// Ports: clk, rst (async, active-high); s_axil_* packed per-requester slave ports, requester i at
//   slice i; m_axil_* single master port to the SRAM. Define SVC_AXIL_SRAM_ARB_RR_EN for round-robin
//   arbitration, otherwise fixed priority (lowest index wins).
module svc_axil_sram_arb #(
  parameter int NUM_M = 2,
  parameter int AXIL_ADDR_WIDTH = 16,
  parameter int AXIL_DATA_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_M*AXIL_ADDR_WIDTH-1:0]       s_axil_awaddr,
  input  logic [NUM_M-1:0]                       s_axil_awvalid,
  output logic [NUM_M-1:0]                       s_axil_awready,
  input  logic [NUM_M*AXIL_DATA_WIDTH-1:0]       s_axil_wdata,
  input  logic [NUM_M*AXIL_DATA_WIDTH/8-1:0]     s_axil_wstrb,
  input  logic [NUM_M-1:0]                       s_axil_wvalid,
  output logic [NUM_M-1:0]                       s_axil_wready,
  output logic [NUM_M*2-1:0]                     s_axil_bresp,
  output logic [NUM_M-1:0]                       s_axil_bvalid,
  input  logic [NUM_M-1:0]                       s_axil_bready,
  input  logic [NUM_M*AXIL_ADDR_WIDTH-1:0]       s_axil_araddr,
  input  logic [NUM_M-1:0]                       s_axil_arvalid,
  output logic [NUM_M-1:0]                       s_axil_arready,
  output logic [NUM_M*AXIL_DATA_WIDTH-1:0]       s_axil_rdata,
  output logic [NUM_M*2-1:0]                     s_axil_rresp,
  output logic [NUM_M-1:0]                       s_axil_rvalid,
  input  logic [NUM_M-1:0]                       s_axil_rready,
  output logic [AXIL_ADDR_WIDTH-1:0]             m_axil_awaddr,
  output logic                                   m_axil_awvalid,
  input  logic                                   m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]             m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0]           m_axil_wstrb,
  output logic                                   m_axil_wvalid,
  input  logic                                   m_axil_wready,
  input  logic [1:0]                             m_axil_bresp,
  input  logic                                   m_axil_bvalid,
  output logic                                   m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]             m_axil_araddr,
  output logic                                   m_axil_arvalid,
  input  logic                                   m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]             m_axil_rdata,
  input  logic [1:0]                             m_axil_rresp,
  input  logic                                   m_axil_rvalid,
  output logic                                   m_axil_rready
);
  localparam int AW = AXIL_ADDR_WIDTH;
  localparam int DW = AXIL_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int GW = $clog2(NUM_M);
  typedef enum logic [2:0] {IDLE, W_ADDR, R_ADDR, W_RESP, R_RESP} state_t;
  state_t state, state_next;
  logic [GW-1:0] grant, last_grant, pick;
  logic [NUM_M-1:0] wr_req, rd_req, req, sel;
  logic aw_done, w_done, in_w, in_r, in_b, in_rr;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  assign wr_req = s_axil_awvalid & s_axil_wvalid;
  assign rd_req = s_axil_arvalid;
  assign req = wr_req | rd_req;
  assign sel = {{(NUM_M-1){1'b0}}, 1'b1} << grant;
  assign in_w = state == W_ADDR;
  assign in_r = state == R_ADDR;
  assign in_b = state == W_RESP;
  assign in_rr = state == R_RESP;
  // Lowest requesting index; in round-robin mode the lowest index above
  // last_grant overrides it, which wraps the search back to 0 when none is above.
  always_comb begin
    pick = '0;
    for (int k = NUM_M - 1; k >= 0; k--)
      if (req[k]) pick = GW'(k);
`ifdef SVC_AXIL_SRAM_ARB_RR_EN
    for (int k = NUM_M - 1; k >= 0; k--)
      if (req[k] && GW'(k) > last_grant) pick = GW'(k);
`endif
  end
`ifndef SVC_AXIL_SRAM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif
  assign m_axil_awaddr = in_w ? s_axil_awaddr[int'(grant)*AW +: AW] : '0;
  assign m_axil_wdata = in_w ? s_axil_wdata[int'(grant)*DW +: DW] : '0;
  assign m_axil_wstrb = in_w ? s_axil_wstrb[int'(grant)*SW +: SW] : '0;
  assign m_axil_awvalid = in_w & ~aw_done & s_axil_awvalid[grant];
  assign m_axil_wvalid = in_w & ~w_done & s_axil_wvalid[grant];
  assign m_axil_araddr = in_r ? s_axil_araddr[int'(grant)*AW +: AW] : '0;
  assign m_axil_arvalid = in_r & s_axil_arvalid[grant];
  assign m_axil_bready = in_b & s_axil_bready[grant];
  assign m_axil_rready = in_rr & s_axil_rready[grant];
  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs = m_axil_wvalid & m_axil_wready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign b_hs = m_axil_bvalid & m_axil_bready;
  assign r_hs = m_axil_rvalid & m_axil_rready;
  for (genvar i = 0; i < NUM_M; i++) begin : g_s
    assign s_axil_awready[i] = sel[i] & in_w & ~aw_done & m_axil_awready;
    assign s_axil_wready[i] = sel[i] & in_w & ~w_done & m_axil_wready;
    assign s_axil_arready[i] = sel[i] & in_r & m_axil_arready;
    assign s_axil_bvalid[i] = sel[i] & in_b & m_axil_bvalid;
    assign s_axil_bresp[2*i +: 2] = (sel[i] & in_b) ? m_axil_bresp : 2'b00;
    assign s_axil_rvalid[i] = sel[i] & in_rr & m_axil_rvalid;
    assign s_axil_rresp[2*i +: 2] = (sel[i] & in_rr) ? m_axil_rresp : 2'b00;
    assign s_axil_rdata[i*DW +: DW] = (sel[i] & in_rr) ? m_axil_rdata : '0;
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = wr_req[pick] ? W_ADDR : R_ADDR;
      W_ADDR:  if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = W_RESP;
      R_ADDR:  if (ar_hs) state_next = R_RESP;
      W_RESP:  if (b_hs) state_next = IDLE;
      R_RESP:  if (r_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      last_grant <= GW'(NUM_M - 1);
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      grant <= (state == IDLE) ? pick : grant;
      aw_done <= (state == IDLE) ? 1'b0 : aw_done | aw_hs;
      w_done <= (state == IDLE) ? 1'b0 : w_done | w_hs;
      last_grant <= (b_hs | r_hs) ? grant : last_grant;
    end
  end
endmodule

// File: tb/tb_svc_axil_sram_arb.sv
// tb_svc_axil_sram_arb: directed vector bench for svc_axil_sram_arb with a behavioural SRAM target
module tb_svc_axil_sram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0] s_wstrb, s_bresp, s_rresp;
  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [15:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [1:0] m_wstrb, m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  svc_axil_sram_arb #(.NUM_M(2), .AXIL_ADDR_WIDTH(16), .AXIL_DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
    .s_axil_araddr(s_araddr), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
    .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
  );
  always #5 clk = ~clk;
  // Behavioural SRAM target: aw/w accepted independently, wready stalled wdly cycles, one outstanding op.
  logic [15:0] mem [0:255];
  logic aw_got, w_got;
  logic [7:0] wa;
  logic [15:0] wd;
  logic [1:0] ws;
  int wdly = 0;
  int wcnt;
  assign m_bresp = 2'b00;
  assign m_rresp = 2'b00;
  assign m_awready = !aw_got && !m_bvalid;
  assign m_wready = !w_got && !m_bvalid && (wcnt >= wdly);
  assign m_arready = !m_rvalid;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0; wcnt <= 0;
    end else begin
      if (m_wvalid && !m_wready) wcnt <= wcnt + 1;
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; wa <= m_awaddr[7:0]; end
      if (m_wvalid && m_wready) begin w_got <= 1'b1; wd <= m_wdata; ws <= m_wstrb; wcnt <= 0; end
      if (aw_got && w_got) begin
        if (ws[0]) mem[wa][7:0] <= wd[7:0];
        if (ws[1]) mem[wa][15:8] <= wd[15:8];
        m_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin m_rvalid <= 1'b1; m_rdata <= mem[m_araddr[7:0]]; end
      else if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  end
  // Handshake log: 10+i aw, 20+i b, 30+i ar, 40+i r; plus per-requester ready pulse counters.
  int evlog[$];
  int awp[2], wp[2];
  int v1cnt = 0, maw = 0;
  always @(negedge clk) if (!rst) begin
    for (int i = 0; i < 2; i++) begin
      if (s_awvalid[i] && s_awready[i]) evlog.push_back(10 + i);
      if (s_bvalid[i] && s_bready[i]) evlog.push_back(20 + i);
      if (s_arvalid[i] && s_arready[i]) evlog.push_back(30 + i);
      if (s_rvalid[i] && s_rready[i]) evlog.push_back(40 + i);
      if (s_awready[i]) awp[i]++;
      if (s_wready[i]) wp[i]++;
    end
    if (s_awready[1] | s_wready[1] | s_bvalid[1] | s_arready[1] | s_rvalid[1]) v1cnt++;
    if (m_awvalid && m_awready) maw++;
  end
  int tests = 0, fails = 0, tmo = 0, early = 0, unstable = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " valids/readys"}, {22'd0, s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk({tag, " s data/resp"}, {s_bresp | s_rresp, 12'd0} | s_rdata, 0);
    chk({tag, " m addr/data"}, {m_awaddr | m_wdata | m_araddr, 14'd0, m_wstrb}, 0);
  endtask
  task automatic wr(input int r, input logic [15:0] a, input logic [15:0] d, input int wgap,
                    output logic [1:0] resp);
    logic ha, hw, got;
    int n;
    s_awaddr[r*16 +: 16] = a; s_wdata[r*16 +: 16] = d; s_wstrb[r*2 +: 2] = 2'b11;
    s_awvalid[r] = 1'b1; s_wvalid[r] = (wgap == 0);
    resp = 2'bxx;
    for (n = 0; n < 200 && (s_awvalid[r] || s_wvalid[r]); n++) begin
      @(negedge clk);
      ha = s_awvalid[r] & s_awready[r];
      hw = s_wvalid[r] & s_wready[r];
      if (s_bvalid[r]) early++;
      @(posedge clk); #1;
      if (ha) s_awvalid[r] = 1'b0;
      if (hw) s_wvalid[r] = 1'b0;
      if (n + 1 == wgap) s_wvalid[r] = 1'b1;
    end
    if (n == 200) tmo++;
    s_awvalid[r] = 1'b0; s_wvalid[r] = 1'b0;
    s_bready[r] = 1'b1; got = 1'b0;
    for (n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (s_bvalid[r]) begin got = 1'b1; resp = s_bresp[r*2 +: 2]; end
      @(posedge clk); #1;
    end
    if (!got) tmo++;
    s_bready[r] = 1'b0;
  endtask
  task automatic rd(input int r, input logic [15:0] a, input int hold,
                    output logic [15:0] d, output logic [1:0] resp, output int held);
    logic ha, got;
    int n;
    s_araddr[r*16 +: 16] = a; s_arvalid[r] = 1'b1;
    d = 16'hxxxx; resp = 2'bxx; held = 0;
    for (n = 0; n < 200 && s_arvalid[r]; n++) begin
      @(negedge clk);
      ha = s_arready[r];
      @(posedge clk); #1;
      if (ha) s_arvalid[r] = 1'b0;
    end
    if (n == 200) tmo++;
    s_arvalid[r] = 1'b0;
    s_rready[r] = (hold == 0); got = 1'b0;
    for (n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (s_rvalid[r]) begin
        if (held == 0 && !s_rready[r]) d = s_rdata[r*16 +: 16];
        else if (!s_rready[r] && s_rdata[r*16 +: 16] !== d) unstable++;
        if (s_rready[r]) begin
          if (held > 0 && s_rdata[r*16 +: 16] !== d) unstable++;
          d = s_rdata[r*16 +: 16]; resp = s_rresp[r*2 +: 2]; got = 1'b1;
        end else held++;
      end
      @(posedge clk); #1;
      if (held >= hold) s_rready[r] = 1'b1;
    end
    if (!got) tmo++;
    s_rready[r] = 1'b0;
  endtask
  typedef struct {
    int r;
    bit wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] ed;
  } vec_t;
  vec_t vt[13];
  task automatic apply(input int lo, input int hi);
    logic [1:0] resp;
    logic [15:0] d;
    int h;
    for (int k = lo; k <= hi; k++) begin
      if (vt[k].wr) begin
        wr(vt[k].r, vt[k].a, vt[k].d, 0, resp);
        chk($sformatf("vec%0d bresp", k), {30'd0, resp}, 0);
      end else begin
        rd(vt[k].r, vt[k].a, 0, d, resp, h);
        chk($sformatf("vec%0d rdata", k), {16'd0, d}, {16'd0, vt[k].ed});
        chk($sformatf("vec%0d rresp", k), {30'd0, resp}, 0);
      end
    end
  endtask
  initial begin
    logic [1:0] resp, rs0 [4], rs1 [4], resp1;
    logic [15:0] d, d1;
    logic got;
    int h, h1, s0, s1, s2, s3, ls;
    int bev[$], ev[$], exp_ev[$];
    vt[0] = '{0, 1'b1, 16'h0040, 16'h1234, 16'h0000};
    vt[1] = '{0, 1'b0, 16'h0040, 16'h0000, 16'h1234};
    vt[2] = '{1, 1'b1, 16'h0041, 16'hBEEF, 16'h0000};
    vt[3] = '{1, 1'b0, 16'h0041, 16'h0000, 16'hBEEF};
    vt[4] = '{0, 1'b0, 16'h0040, 16'h0000, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      vt[5+i] = '{0, 1'b0, 16'h0010 + 16'(i), 16'h0000, 16'hA000 + 16'(i)};
      vt[9+i] = '{0, 1'b0, 16'h0014 + 16'(i), 16'h0000, 16'hB000 + 16'(i)};
    end
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    repeat (3) @(posedge clk); #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    // 1: reset while a write response is pending
    s_awaddr[15:0] = 16'h0022; s_wdata[15:0] = 16'h5555; s_wstrb[1:0] = 2'b11;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin @(negedge clk); got = s_bvalid[0]; end
    chk("t1 bvalid pending", {31'd0, got}, 1);
    rst = 1'b1; s_awvalid = '0; s_wvalid = '0;
    @(posedge clk); #1;
    chk_idle("t1 mid-resp reset");
    chk("t1 state", 32'(dut.state), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    wr(0, 16'h0022, 16'h6666, 0, resp);
    chk("t1 post-reset bresp", {30'd0, resp}, 0);
    rd(0, 16'h0022, 0, d, resp, h);
    chk("t1 post-reset rdata", {16'd0, d}, 32'h6666);
    // 2: single write/read by req0, req1 untouched
    s0 = v1cnt;
    apply(0, 1);
    chk("t2 req1 quiet", v1cnt - s0, 0);
    apply(2, 4);
    // 3: split aw/w on req1 with a stalled wready
    wdly = 2; s0 = awp[1]; s1 = wp[1]; s2 = early; s3 = maw;
    wr(1, 16'h0030, 16'h3333, 3, resp);
    wdly = 0;
    chk("t3 bresp", {30'd0, resp}, 0);
    chk("t3 awready pulses", awp[1] - s0, 1);
    chk("t3 wready pulses", wp[1] - s1, 1);
    chk("t3 early bvalid", early - s2, 0);
    chk("t3 m writes", maw - s3, 1);
    rd(1, 16'h0030, 0, d, resp, h);
    chk("t3 rdata", {16'd0, d}, 32'h3333);
    // 4/5: contention, 4 back-to-back writes from each requester
    ls = evlog.size();
    fork
      for (int i = 0; i < 4; i++) wr(0, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 0, rs0[i]);
      for (int i = 0; i < 4; i++) wr(1, 16'h0014 + 16'(i), 16'hB000 + 16'(i), 0, rs1[i]);
    join
    chk("t4 bresps", {24'd0, rs0[0], rs0[1], rs0[2], rs0[3]} | {24'd0, rs1[0], rs1[1], rs1[2], rs1[3]}, 0);
    for (int k = ls; k < evlog.size(); k++) if (evlog[k] / 10 == 2) bev.push_back(evlog[k] % 10);
    chk("t4 b count", bev.size(), 8);
    for (int k = 0; k < 8; k++) begin
`ifdef SVC_AXIL_SRAM_ARB_RR_EN
      chk($sformatf("t4 rr order %0d", k), (k < bev.size()) ? bev[k] : -1, k % 2);
`else
      chk($sformatf("t5 fixed order %0d", k), (k < bev.size()) ? bev[k] : -1, (k < 4) ? 0 : 1);
`endif
    end
    apply(5, 12);
    // 6: read back-pressure on req0 while req1 read waits
    ls = evlog.size();
    fork
      rd(0, 16'h0010, 5, d, resp, h);
      begin
        repeat (3) @(posedge clk); #1;
        rd(1, 16'h0014, 0, d1, resp1, h1);
      end
    join
    chk("t6 rdata0", {16'd0, d}, 32'hA000);
    chk("t6 held", h, 5);
    chk("t6 unstable", unstable, 0);
    chk("t6 rdata1", {16'd0, d1}, 32'hB000);
    for (int k = ls; k < evlog.size(); k++) ev.push_back(evlog[k]);
    exp_ev = '{30, 40, 31, 41};
    chk("t6 event count", ev.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t6 event %0d", k), (k < ev.size()) ? ev[k] : -1, exp_ev[k]);
    chk("timeouts", tmo, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
